// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch controller.
// State encoding, instruction size and the canonical NOP word.
package fetch_pkg;

   localparam logic [2:0] S_BOOT  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DROP  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pc_incr.sv
// pc_incr: sequential next-PC adder (pc + INSTR_BYTES).
// Wraps silently at 2^XLEN; shared with the branch unit.
module pc_incr
   import fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] pc_o
);

   // plain modular add of one instruction width
   always_comb begin
      pc_o = pc_i + XLEN'(INSTR_BYTES);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with
// a one-entry decode buffer; stalls the PC by echoing pc.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   output logic            misaligned_fault
);

   logic [2:0]      state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] ipc_q, ipc_d;
   logic [XLEN-1:0] pc_plus;
   logic            misal;
   logic            hs;

   pc_incr #(.XLEN(XLEN)) u_incr (
      .pc_i (pc),
      .pc_o (pc_plus)
   );

   assign misal = |pc[1:0];
   assign hs    = imem_req_valid & imem_req_ready;

   // a misaligned PC never reaches memory
   assign imem_req_valid   = (state_q == S_REQ) & ~misal;
   assign imem_req_addr    = pc;
   assign instr_valid      = (state_q == S_HOLD);
   assign misaligned_fault = (state_q == S_FAULT);
   assign instr            = instr_q;
   assign instr_pc         = ipc_q;

   // next state, PC steering and buffer capture
   always_comb begin
      state_d = state_q;
      pc_next = pc;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      unique case (state_q)
         S_BOOT: begin
            pc_next = RESET_PC;
            state_d = S_REQ;
         end
         S_REQ: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               state_d = hs ? S_DROP : S_REQ;
            end else if (misal) begin
               state_d = S_FAULT;
            end else if (hs) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               state_d = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem_rsp_valid) begin
               instr_d = imem_rsp_data;
               ipc_d   = pc;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               state_d = S_REQ;
            end else if (instr_ready) begin
               pc_next = pc_plus;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
            end else if (imem_rsp_valid) begin
               state_d = S_REQ;
            end
         end
         S_FAULT: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // state and instruction buffer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_BOOT;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, pc_next;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr, instr_pc;
   logic        instr_ready;
   logic        misaligned_fault;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   bit          m_boot, m_out, m_sq, m_have, m_fault;
   logic [31:0] m_instr, m_ipc;
   bit          mem_pend;
   int          mem_cnt;

   always #5 clk = ~clk;

   // the PC register that owns pc (no enable)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc <= '0;
      else      pc <= pc_next;
   end

   fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc               (pc),
      .pc_next          (pc_next),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .instr_valid      (instr_valid),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_ready      (instr_ready),
      .misaligned_fault (misaligned_fault)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   function automatic void model_reset();
      m_boot  = 1'b1;
      m_out   = 1'b0;
      m_sq    = 1'b0;
      m_have  = 1'b0;
      m_fault = 1'b0;
      m_instr = '0;
      m_ipc   = '0;
   endfunction

   task automatic drv(input bit rdy, input bit rv,
                      input logic [31:0] rd, input bit rdr,
                      input logic [31:0] tgt, input bit ir);
      imem_req_ready  = rdy;
      imem_rsp_valid  = rv;
      imem_rsp_data   = rd;
      redirect_valid  = rdr;
      redirect_target = tgt;
      instr_ready     = ir;
   endtask

   // compare one cycle against the model, then advance it
   task automatic tick();
      logic [31:0] e_next, s_pc, s_data;
      bit e_req, hs, s_rst, s_rdy, s_rsp, s_rdr, s_ir;
      #1;
      if (!rst) begin
         model_reset();
         mem_pend = 1'b0;
      end
      e_req = !m_boot && !m_out && !m_have && !m_fault
              && (pc[1:0] == 2'b00);
      if (m_boot)                     e_next = RST_PC;
      else if (redirect_valid)        e_next = redirect_target;
      else if (m_have && instr_ready) e_next = pc + 32'd4;
      else                            e_next = pc;
      chk("req_valid", imem_req_valid, e_req);
      chk("req_addr", imem_req_addr, pc);
      chk("pc_next", pc_next, e_next);
      chk("instr_valid", instr_valid, m_have);
      chk("fault", misaligned_fault, m_fault);
      if (m_have || !rst) begin
         chk("instr", instr, m_instr);
         chk("instr_pc", instr_pc, m_ipc);
      end
      s_rst  = rst;
      s_rdy  = imem_req_ready;
      s_rsp  = imem_rsp_valid;
      s_data = imem_rsp_data;
      s_rdr  = redirect_valid;
      s_ir   = instr_ready;
      s_pc   = pc;
      hs     = e_req && s_rdy;
      @(posedge clk);
      if (s_rst) begin
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (s_rdr) begin
            if (m_fault) m_fault = 1'b0;
            else if (m_have) m_have = 1'b0;
            else if (m_out) begin
               if (!m_sq) begin
                  if (s_rsp) m_out = 1'b0;
                  else       m_sq = 1'b1;
               end
            end else if (hs) begin
               m_out = 1'b1;
               m_sq  = 1'b1;
            end
         end else begin
            if (m_fault) begin
            end else if (m_have) begin
               if (s_ir) m_have = 1'b0;
            end else if (m_out) begin
               if (s_rsp) begin
                  if (!m_sq) begin
                     m_have  = 1'b1;
                     m_instr = s_data;
                     m_ipc   = s_pc;
                  end
                  m_out = 1'b0;
                  m_sq  = 1'b0;
               end
            end else if (s_pc[1:0] != 2'b00) begin
               m_fault = 1'b1;
            end else if (hs) begin
               m_out = 1'b1;
               m_sq  = 1'b0;
            end
         end
         if (s_rsp) mem_pend = 1'b0;
         else if (mem_pend && mem_cnt > 0) mem_cnt--;
         if (hs) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(0, 2));
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      mem_pend = 1'b0;
      mem_cnt  = 0;
      drv(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", imem_req_valid, 0);
      chk("rst_iv", instr_valid, 0);
      chk("rst_fault", misaligned_fault, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ipc", instr_pc, 0);
      tick();
      // boot
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      #1 chk("boot_pc_next", pc_next, 32'h100);
      tick();
      drv(1, 0, 0, 0, 0, 0);
      #1;
      chk("first_req", imem_req_valid, 1);
      chk("first_addr", imem_req_addr, 32'h100);
      tick();
      drv(0, 1, 32'h00500093, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0, 1);
      #1;
      chk("sl_iv", instr_valid, 1);
      chk("sl_instr", instr, 32'h00500093);
      chk("sl_ipc", instr_pc, 32'h100);
      chk("sl_next", pc_next, 32'h104);
      tick();
      // request backpressure
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 0, 0, 0, 0);
         #1;
         chk("bp_addr", imem_req_addr, 32'h104);
         chk("bp_next", pc_next, 32'h104);
         tick();
      end
      drv(1, 0, 0, 0, 0, 0);
      tick();
      drv(0, 1, 32'h00100113, 0, 0, 0);
      tick();
      // decode backpressure
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0, 0, 0);
         #1;
         chk("hold_instr", instr, 32'h00100113);
         chk("hold_next", pc_next, 32'h104);
         tick();
      end
      drv(0, 0, 0, 0, 0, 1);
      #1 chk("hold_cons", pc_next, 32'h108);
      tick();
      // redirect while waiting
      drv(1, 0, 0, 0, 0, 0);
      tick();
      drv(0, 0, 0, 1, 32'h200, 0);
      #1 chk("rw_next", pc_next, 32'h200);
      tick();
      drv(0, 1, 32'hDEADBEEF, 0, 0, 0);
      #1 chk("drop_iv", instr_valid, 0);
      tick();
      drv(1, 0, 0, 0, 0, 0);
      #1;
      chk("rw_req", imem_req_valid, 1);
      chk("rw_addr", imem_req_addr, 32'h200);
      tick();
      drv(0, 1, 32'h11111111, 0, 0, 0);
      tick();
      // redirect in HOLD with consume
      drv(0, 0, 0, 1, 32'h200, 1);
      #1 chk("rh_next", pc_next, 32'h200);
      tick();
      drv(0, 0, 0, 1, 32'h202, 0);
      #1 chk("rh_iv", instr_valid, 0);
      tick();
      // misaligned target
      drv(1, 0, 0, 0, 0, 0);
      #1 chk("mis_req", imem_req_valid, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drv(1, 0, 0, 0, 0, 0);
         #1;
         chk("mis_fault", misaligned_fault, 1);
         chk("mis_noreq", imem_req_valid, 0);
         tick();
      end
      drv(0, 0, 0, 1, 32'h300, 0);
      tick();
      drv(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      #1;
      chk("clr_fault", misaligned_fault, 0);
      chk("clr_addr", imem_req_addr, 32'h300);
      tick();
      // wrap
      drv(1, 0, 0, 0, 0, 0);
      tick();
      drv(0, 1, NOP, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0, 1);
      #1;
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_next", pc_next, 32'h0);
      tick();
      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         logic [31:0] tgt;
         logic [31:0] rd;
         bit rv;
         rst = ($urandom_range(0, 299) != 0);
         rd  = $urandom;
         if (mem_pend && mem_cnt == 0) rv = 1'b1;
         else if (!mem_pend && $urandom_range(0, 7) == 0) rv = 1'b1;
         else rv = 1'b0;
         case ($urandom_range(0, 7))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFFC;
            default: tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         endcase
         drv(bit'($urandom_range(0, 1)), rv, rd,
             ($urandom_range(0, 9) == 0), tgt,
             bit'($urandom_range(0, 1)));
         tick();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch controller sitting directly downstream of the PC register. It consumes `pc` and issues a valid/ready request to instruction memory. It buffers the returned word for the decode stage and produces `pc_next` for the PC register. Because the PC register has no enable, the block holds `pc_next == pc` while a fetch is outstanding, which stalls the PC.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address driven onto `pc_next` after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  input  XLEN  current PC from the PC register.
- pc_next  output  XLEN  next PC to the PC register; combinational.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address; always equals `pc`.
- imem_rsp_valid  input  1  response word valid; arrives at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  branch/jump taken, 1-cycle pulse.
- redirect_target  input  XLEN  redirect address.
- instr_valid  output  1  buffered instruction valid.
- instr  output  32  buffered instruction.
- instr_pc  output  XLEN  PC of the buffered instruction.
- instr_ready  input  1  decode consumes the instruction.
- misaligned_fault  output  1  `pc[1:0] != 0`; held until redirect.

Behaviour:
- **Reset values** (`rst` = 0): state = BOOT; `instr` = 0; `instr_pc` = 0; `instr_valid` = 0; `imem_req_valid` = 0; `misaligned_fault` = 0.
- **Reset mid-operation:** any outstanding response is ignored. The block restarts at BOOT.
- **Output decoding:**
  - `imem_req_valid` = (state == REQ).
  - `instr_valid` = (state == HOLD).
  - `misaligned_fault` = (state == FAULT).
- **`pc_next` default:** `pc` (hold).
- **States and transitions:**
  - BOOT: `pc_next` = RESET_PC. Next state is REQ, unconditionally.
  - REQ:
    - If `pc[1:0] != 0` → FAULT; no request is issued (`imem_req_valid` forced 0).
    - Else, on `imem_req_valid && imem_req_ready` → WAIT.
  - WAIT: on `imem_rsp_valid`, capture `instr` ← `imem_rsp_data` and `instr_pc` ← `pc`, then → HOLD.
  - HOLD: on `instr_ready`, `pc_next` = `pc` + 4 (mod 2^XLEN, wraps silently) → REQ.
  - DROP: waits for the squashed response. On `imem_rsp_valid`, discard the data → REQ.
  - FAULT: waits for a redirect.
- **Redirect** (highest priority, any state except BOOT): `pc_next` = `redirect_target`. Next state depends on the current state:
  - REQ with handshake in the same cycle → DROP.
  - REQ without handshake → REQ (the new `pc` is visible next cycle).
  - WAIT → DROP, unless `imem_rsp_valid` in the same cycle; then the data is discarded → REQ.
  - HOLD → REQ. `instr_valid` falls next cycle; `instr_ready` in the same cycle is ignored.
  - DROP → DROP.
  - FAULT → REQ.
- **Responses outside WAIT/DROP** are ignored.
- **Throughput:** minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and decode.
- **Timing:** all state changes occur on the clock edge. The PC register updates from `pc_next` on the same edge.

Decomposition:
- Shared package `fetch_pkg` holds:
  - the state encoding (BOOT, REQ, WAIT, HOLD, DROP, FAULT), 3 bits;
  - the INSTR_BYTES = 4 constant;
  - the NOP = 32'h0000_0013 constant, used by benches.
- One sub-module, `pc_incr`: combinational `pc` + INSTR_BYTES adder, reused by the branch unit.
- The FSM and buffer stay in `fetch_ctrl`.

Test Plan:
- **Reset and boot:** release `rst` with `pc` register at 0 and RESET_PC = 32'h100 → cycle 1: `pc_next` = 32'h100; cycle 2: `imem_req_valid` = 1, `imem_req_addr` = 32'h100.
- **Straight-line fetch:** ready always 1, memory returns 32'h00500093 one cycle after acceptance → `instr_valid` in the 3rd cycle with `instr` = 32'h00500093 and `instr_pc` = 32'h100; `pc_next` = 32'h104 on consume.
- **Backpressure:** `imem_req_ready` = 0 for 4 cycles, then `instr_ready` = 0 for 3 cycles → `imem_req_addr` is stable and `pc_next` == `pc` throughout; `instr` is held unchanged while in HOLD.
- **Redirect in WAIT:** redirect to 32'h200 while waiting → the late response 32'hDEADBEEF is never presented; the next request address is 32'h200.
- **Redirect in HOLD together with `instr_ready`:** → `pc_next` = 32'h200, not `pc` + 4; `instr_valid` drops next cycle.
- **Misaligned target and wrap:**
  - Redirect to 32'h202 → `misaligned_fault` = 1 and no request is issued; a redirect to 32'h300 clears the fault.
  - With `pc` = 32'hFFFF_FFFC, consume → `pc_next` = 0.
